// File: rtl/ifu_bus_pkg.sv
// Shared types and constants for the IFU instruction-memory handshake.
package ifu_bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } ifu_state_e;

  localparam logic [31:0] BaseAddrDefault = 32'h8000_0000;
  localparam logic [31:0] ErrRdata        = 32'h0000_0000;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left.
  localparam logic [7:0] LfsrSeed = 8'hA5;
  localparam logic [7:0] LfsrTaps = 8'hB8;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/imem_lfsr8.sv
// 8-bit maximal-length LFSR used to jitter the response latency.
module imem_lfsr8
  import ifu_bus_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q, lfsr_d;

  // Next value: advance when enabled, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = lfsr8_next(lfsr_q);
  end

  // State register; seed must be nonzero or the sequence locks up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LfsrSeed;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ifu_imem_resp.sv
// Instruction-memory responder: accepts one fetch at a time and answers after a
// programmable (optionally jittered) latency with a one-cycle valid pulse.
module ifu_imem_resp
  import ifu_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = BaseAddrDefault,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned RAND_EN     = 0,
  parameter int unsigned JITTER_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ifu_reqValid,
  input  logic [31:0]              ifu_raddr,
  output logic                     ifu_respValid,
  output logic [31:0]              ifu_rdata,
  output logic                     resp_err,
  output logic                     req_drop,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  // Wide enough for LATENCY-1 (up to 254) plus the largest jitter.
  localparam int unsigned CntW  = ((JITTER_BITS > 8) ? JITTER_BITS : 8) + 1;

  ifu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic            req_drop_q, req_drop_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem_q [DEPTH];
  logic [7:0]      lfsr;
  logic [CntW-1:0] jitter;
  logic [31:0]     off;
  logic            addr_err;
  logic [AddrW-1:0] idx;
  logic            resp_fire;
  logic            unused_bits;

  imem_lfsr8 u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (1'b1),
    .lfsr_o (lfsr)
  );

  assign jitter = (RAND_EN != 0) ? CntW'(lfsr[JITTER_BITS-1:0]) : '0;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign off       = addr_q - BASE_ADDR;
  assign addr_err  = (addr_q[1:0] != 2'b00) || ((off >> (AddrW + 2)) != 32'd0);
  assign idx       = off[AddrW+1:2];
  assign resp_fire = (state_q == StBusy) && (cnt_q == '0);

  assign unused_bits = ^{lfsr, off[1:0]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state, latency counter and captured address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (ifu_reqValid) begin
          state_d = StBusy;
          addr_d  = ifu_raddr;
          cnt_d   = CntW'(LATENCY - 1) + jitter;
        end
      end
      StBusy: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: response pulse on the counter-expiry edge, drop pulse on busy requests.
  always_comb begin
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = rdata_q;
    req_drop_d   = ifu_reqValid && (state_q != StIdle);
    if (resp_fire) begin
      resp_valid_d = 1'b1;
      resp_err_d   = addr_err;
      // Read uses pre-edge contents, so a same-edge preload is not returned.
      rdata_d      = addr_err ? ErrRdata : mem_q[idx];
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      req_drop_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      req_drop_q   <= req_drop_d;
      rdata_q      <= rdata_d;
    end
  end

  // Preload write port; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  assign ifu_respValid = resp_valid_q;
  assign ifu_rdata     = rdata_q;
  assign resp_err      = resp_err_q;
  assign req_drop      = req_drop_q;

endmodule

// File: tb/tb_ifu_imem_resp.sv
// Bench for ifu_imem_resp: three instances (LATENCY 1, LATENCY 3, jittered LATENCY 2)
// with a per-instance expected-response queue checked by a negedge monitor.
module tb_ifu_imem_resp;

  localparam logic [31:0] Base = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned lo;
    int unsigned hi;
    int unsigned req_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int unsigned cyc = 0;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [3:0] seen_lat = 4'b0000;

  logic        l1_req = 0, l3_req = 0, rn_req = 0;
  logic [31:0] l1_addr = 0, l3_addr = 0, rn_addr = 0;
  logic        l1_le = 0, l3_le = 0, rn_le = 0;
  logic [11:0] l1_la = 0, l3_la = 0, rn_la = 0;
  logic [31:0] l1_ld = 0, l3_ld = 0, rn_ld = 0;
  logic        l1_rv, l3_rv, rn_rv, l1_err, l3_err, rn_err, l1_drop, l3_drop, rn_drop;
  logic [31:0] l1_rd, l3_rd, rn_rd;
  logic        p1 = 0, p3 = 0, pr = 0;

  exp_t q1[$], q3[$], qr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifu_imem_resp #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .ifu_reqValid(l1_req), .ifu_raddr(l1_addr),
    .ifu_respValid(l1_rv), .ifu_rdata(l1_rd), .resp_err(l1_err), .req_drop(l1_drop),
    .load_en(l1_le), .load_addr(l1_la), .load_data(l1_ld)
  );

  ifu_imem_resp #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .ifu_reqValid(l3_req), .ifu_raddr(l3_addr),
    .ifu_respValid(l3_rv), .ifu_rdata(l3_rd), .resp_err(l3_err), .req_drop(l3_drop),
    .load_en(l3_le), .load_addr(l3_la), .load_data(l3_ld)
  );

  ifu_imem_resp #(.LATENCY(2), .RAND_EN(1), .JITTER_BITS(2)) u_rn (
    .clk(clk), .rst_n(rst_n), .ifu_reqValid(rn_req), .ifu_raddr(rn_addr),
    .ifu_respValid(rn_rv), .ifu_rdata(rn_rd), .resp_err(rn_err), .req_drop(rn_drop),
    .load_en(rn_le), .load_addr(rn_la), .load_data(rn_ld)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 32'h%08h, expected 32'h%08h", name, got, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic e, input int unsigned lo,
                              input int unsigned hi);
    exp_t x;
    x.data = d; x.err = e; x.lo = lo; x.hi = hi; x.req_cyc = 0;
    return x;
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q1.size();
      1:       return q3.size();
      default: return qr.size();
    endcase
  endfunction

  task automatic set_req(input int sel, input logic v, input logic [31:0] a);
    case (sel)
      0:       begin l1_req = v; l1_addr = a; end
      1:       begin l3_req = v; l3_addr = a; end
      default: begin rn_req = v; rn_addr = a; end
    endcase
  endtask

  task automatic set_load(input int sel, input logic v, input logic [11:0] a,
                          input logic [31:0] d);
    case (sel)
      0:       begin l1_le = v; l1_la = a; l1_ld = d; end
      1:       begin l3_le = v; l3_la = a; l3_ld = d; end
      default: begin rn_le = v; rn_la = a; rn_ld = d; end
    endcase
  endtask

  // Request is sampled at the next posedge, which becomes cycle cyc+1.
  task automatic push(input int sel, input exp_t x);
    x.req_cyc = cyc + 1;
    case (sel)
      0:       q1.push_back(x);
      1:       q3.push_back(x);
      default: qr.push_back(x);
    endcase
  endtask

  task automatic send(input int sel, input logic [31:0] a, input exp_t x);
    set_req(sel, 1'b1, a);
    push(sel, x);
    @(negedge clk);
    set_req(sel, 1'b0, a);
  endtask

  task automatic preload(input int sel, input logic [11:0] a, input logic [31:0] d);
    set_load(sel, 1'b1, a, d);
    @(negedge clk);
    set_load(sel, 1'b0, 12'd0, 32'd0);
  endtask

  // Wait for all expected responses, then one more cycle so the responder is IDLE.
  task automatic drain(input int sel, input int budget);
    int n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(qsize(sel)), 32'd0);
    @(negedge clk);
  endtask

  task automatic on_resp(input int sel, input string tag, input logic [31:0] rd,
                         input logic err, input logic prev);
    exp_t x;
    int unsigned lat;
    check({tag, "_pulse_width"}, 32'(prev), 32'd0);
    check({tag, "_resp_expected"}, 32'(qsize(sel) != 0), 32'd1);
    if (qsize(sel) != 0) begin
      case (sel)
        0:       x = q1.pop_front();
        1:       x = q3.pop_front();
        default: x = qr.pop_front();
      endcase
      check({tag, "_rdata"}, rd, x.data);
      check({tag, "_err"}, 32'(err), 32'(x.err));
      lat = cyc - x.req_cyc;
      total_cnt++;
      if (lat >= x.lo && lat <= x.hi) begin
        pass_cnt++;
        if (sel == 2 && lat >= 2 && lat <= 5) seen_lat[lat-2] = 1'b1;
      end else begin
        $display("FAIL %s_latency: got %0d, expected %0d..%0d", tag, lat, x.lo, x.hi);
      end
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (l1_rv) on_resp(0, "l1", l1_rd, l1_err, p1);
    if (l3_rv) on_resp(1, "l3", l3_rd, l3_err, p3);
    if (rn_rv) on_resp(2, "rn", rn_rd, rn_err, pr);
    p1 = l1_rv;
    p3 = l3_rv;
    pr = rn_rv;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int   quiet;
    logic [3:0] w;
    vecs[0] = '{addr: Base,                 data: 32'h0000_0413, err: 1'b0};
    vecs[1] = '{addr: Base + 32'd4,         data: 32'h1234_5678, err: 1'b0};
    vecs[2] = '{addr: Base + 32'h3FFC,      data: 32'hFEED_0FFF, err: 1'b0};
    vecs[3] = '{addr: Base + 32'd2,         data: 32'h0000_0000, err: 1'b1};
    vecs[4] = '{addr: Base + 32'h4000,      data: 32'h0000_0000, err: 1'b1};
    vecs[5] = '{addr: 32'h7FFF_FFFC,        data: 32'h0000_0000, err: 1'b1};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_respValid", 32'(l1_rv), 32'd0);
    check("reset_rdata", l1_rd, 32'd0);
    check("reset_err", 32'(l1_err), 32'd0);
    check("reset_drop", 32'(l1_drop), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single fetches on the LATENCY=1 instance.
    preload(0, 12'd0, 32'h0000_0413);
    preload(0, 12'd1, 32'h1234_5678);
    preload(0, 12'd4095, 32'hFEED_0FFF);
    for (int i = 0; i < 6; i++) begin
      send(0, vecs[i].addr, mk(vecs[i].data, vecs[i].err, 1, 1));
      drain(0, 20);
    end

    // Preload colliding with the response edge returns the old word.
    preload(0, 12'd5, 32'hAAAA_0005);
    set_req(0, 1'b1, Base + 32'h14);
    push(0, mk(32'hAAAA_0005, 1'b0, 1, 1));
    @(negedge clk);
    set_req(0, 1'b0, 32'd0);
    set_load(0, 1'b1, 12'd5, 32'hBBBB_0005);
    @(negedge clk);
    set_load(0, 1'b0, 12'd0, 32'd0);
    drain(0, 20);
    send(0, Base + 32'h14, mk(32'hBBBB_0005, 1'b0, 1, 1));
    drain(0, 20);

    // LATENCY=3 fetch, then rdata must hold.
    preload(1, 12'd2, 32'hDEAD_BEEF);
    send(1, Base + 32'd8, mk(32'hDEAD_BEEF, 1'b0, 3, 3));
    drain(1, 20);
    repeat (3) @(negedge clk);
    check("l3_hold_rdata", l3_rd, 32'hDEAD_BEEF);
    check("l3_hold_valid", 32'(l3_rv), 32'd0);

    // Second request while BUSY: one drop pulse, one response only.
    set_req(1, 1'b1, Base + 32'd8);
    push(1, mk(32'hDEAD_BEEF, 1'b0, 3, 3));
    @(negedge clk);
    set_req(1, 1'b1, Base + 32'd4);
    @(negedge clk);
    set_req(1, 1'b0, 32'd0);
    check("drop_pulse", 32'(l3_drop), 32'd1);
    @(negedge clk);
    check("drop_clear", 32'(l3_drop), 32'd0);
    drain(1, 20);
    repeat (5) @(negedge clk);

    // Reset during BUSY, asserted mid-cycle with nonzero rdata and drop pending.
    preload(1, 12'd7, 32'h1357_9BDF);
    send(1, Base + 32'h1C, mk(32'h1357_9BDF, 1'b0, 3, 3));
    drain(1, 20);
    set_req(1, 1'b1, Base);
    @(negedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 32'd0);
    check("pre_reset_drop", 32'(l3_drop), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_respValid", 32'(l3_rv), 32'd0);
    check("midreset_rdata", l3_rd, 32'd0);
    check("midreset_err", 32'(l3_err), 32'd0);
    check("midreset_drop", 32'(l3_drop), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (l3_rv) quiet++;
    end
    check("post_reset_no_resp", 32'(quiet), 32'd0);

    // Jittered latency on the RAND_EN instance.
    for (int i = 0; i < 16; i++) preload(2, 12'(i), 32'hC0DE_0000 | 32'(i));
    for (int n = 0; n < 1000; n++) begin
      w = 4'($urandom_range(15));
      send(2, Base + {26'd0, w, 2'b00}, mk(32'hC0DE_0000 | 32'(w), 1'b0, 2, 5));
      drain(2, 20);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) check("rn_latency_seen", 32'(seen_lat[i]), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
